// File: rtl/chan_mux_pkg.sv
// Shared types and default sizing for the channel multiplexer family.
package chan_mux_pkg;

  // Selection mode held in the configuration register.
  typedef enum logic {
    FIXED = 1'b0,
    RR    = 1'b1
  } mode_e;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_WIDTH    = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: finds the first set request strictly after the
// last served index, wrapping from CHANNELS-1 back to 0. Purely combinational.
module rr_pick
  import chan_mux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [SEL_W-1:0]    i_last,
  output logic [SEL_W-1:0]    o_grant,
  output logic                o_any
);

  logic [SEL_W-1:0] w_idx;
  logic             w_hit;

  // Walk the channels in rotation order starting one past the last grant;
  // the first requesting channel wins, the last position checked is i_last.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    w_hit   = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      w_idx   = SEL_W'((int'(i_last) + k) % CHANNELS);
      w_hit   = i_req[w_idx] && !o_any;
      o_grant = w_hit ? w_idx : o_grant;
      o_any   = o_any | w_hit;
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel registered stream multiplexer with valid/ready handshake.
// Selects either a software-fixed channel or round-robin among valid
// channels, and forwards one word per transfer into a single output register.
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_load,
  input  logic                      cfg_mode,
  input  logic [SEL_W-1:0]          cfg_sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  mode_e               r_mode;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    r_last;
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_chan;

  logic                w_can_load;
  logic                w_grant_ok;
  logic                w_xfer;
  logic                w_cfg_ok;
  logic                w_rr_any;
  logic [SEL_W-1:0]    w_rr_grant;
  logic [SEL_W-1:0]    w_grant;
  logic [WIDTH-1:0]    w_grant_data;
  logic [CHANNELS-1:0] w_in_ready;

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_pick (
    .i_req   (in_valid),
    .i_last  (r_last),
    .o_grant (w_rr_grant),
    .o_any   (w_rr_any)
  );

  // Choose the granted channel for the current mode and decide whether a
  // transfer happens; nothing moves while reset is held.
  always_comb begin
    w_can_load = !r_out_valid || out_ready;
    if (r_mode == RR) begin
      w_grant    = w_rr_grant;
      w_grant_ok = w_rr_any;
    end else begin
      w_grant    = r_sel;
      w_grant_ok = in_valid[r_sel];
    end
    w_xfer   = rst_n && w_can_load && w_grant_ok;
    w_cfg_ok = int'(cfg_sel) < CHANNELS;
  end

  // Decode the grant into a one-hot ready and pick the granted channel's data.
  always_comb begin
    w_in_ready   = '0;
    w_grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (SEL_W'(i) == w_grant) begin
        w_in_ready[i] = w_xfer;
        w_grant_data  = in_data[i*WIDTH +: WIDTH];
      end else begin
        w_in_ready[i] = 1'b0;
      end
    end
  end

  // Configuration register; an out-of-range select discards the whole load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode <= FIXED;
      r_sel  <= '0;
    end else if (cfg_load && w_cfg_ok) begin
      r_mode <= mode_e'(cfg_mode);
      r_sel  <= cfg_sel;
    end else begin
      r_mode <= r_mode;
      r_sel  <= r_sel;
    end
  end

  // Round-robin position; only advanced by RR transfers so a mode switch
  // resumes from where RR left off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= SEL_W'(CHANNELS - 1);
    end else if (w_xfer && (r_mode == RR)) begin
      r_last <= w_grant;
    end else begin
      r_last <= r_last;
    end
  end

  // Output register: load on transfer (also when draining the same cycle),
  // otherwise clear valid on drain while data and channel hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_grant_data;
      r_out_chan  <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_data  <= r_out_data;
      r_out_chan  <= r_out_chan;
    end else begin
      r_out_valid <= r_out_valid;
      r_out_data  <= r_out_data;
      r_out_chan  <= r_out_chan;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule
